// File: rtl/uart_pkg.sv
// Shared types and ASCII helpers for the hex printer.
// UART_HEX_PRINTER_PREFIX_EN adds the "0x" prefix states.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
`ifdef UART_HEX_PRINTER_PREFIX_EN
    PFX0  = 3'd1,
    PFX1  = 3'd2,
`endif
    DIGIT = 3'd3,
    TERM0 = 3'd4,
    TERM1 = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_X     = 8'h78;

  function automatic logic [7:0] nibble_to_ascii(
    input logic [3:0] nibble,
    input logic       uppercase
  );
    logic [7:0] n;
    n = {4'd0, nibble};
    if (nibble < 4'd10) return ASCII_ZERO + n;
    return (uppercase ? 8'h41 : 8'h61) + n - 8'd10;
  endfunction

endpackage

// File: rtl/uart_hex_printer.sv
// Prints binary words as ASCII hex plus terminator on a byte stream.
// Define UART_HEX_PRINTER_PREFIX_EN to precede every word with "0x".
module uart_hex_printer
  import uart_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int UPPERCASE  = 1,
  parameter int NEWLINE    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] word_in_data,
  input  logic                    word_in_valid,
  output logic                    word_in_ready,
  output logic [7:0]              byte_out_data,
  output logic                    byte_out_valid,
  input  logic                    byte_out_ready
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int ND = 2 * WORD_BYTES;
  localparam int CW = $clog2(ND) + 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);
  localparam logic UPPER = (UPPERCASE != 0);
  localparam logic NL    = (NEWLINE != 0);
  localparam logic [7:0] T0 = NL ? ASCII_CR : ASCII_SPACE;

  state_t        state;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shnext;
  logic [CW-1:0] cnt;
  logic          take;
  logic          adv;

  assign word_in_ready = (state == IDLE) && !rst;
  assign take   = word_in_valid && word_in_ready;
  assign adv    = byte_out_valid && byte_out_ready;
  assign shnext = shreg << 4;

  // The next character is registered on the same edge that moves state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      byte_out_data  <= 8'h00;
      byte_out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (take) begin
          shreg          <= word_in_data;
          cnt            <= '0;
          byte_out_valid <= 1'b1;
`ifdef UART_HEX_PRINTER_PREFIX_EN
          state          <= PFX0;
          byte_out_data  <= ASCII_ZERO;
`else
          state          <= DIGIT;
          byte_out_data  <=
            nibble_to_ascii(word_in_data[W-1 -: 4], UPPER);
`endif
        end
`ifdef UART_HEX_PRINTER_PREFIX_EN
        PFX0: if (adv) begin
          state         <= PFX1;
          byte_out_data <= ASCII_X;
        end
        PFX1: if (adv) begin
          state         <= DIGIT;
          byte_out_data <= nibble_to_ascii(shreg[W-1 -: 4], UPPER);
        end
`endif
        DIGIT: if (adv) begin
          shreg <= shnext;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state         <= TERM0;
            byte_out_data <= T0;
          end else begin
            byte_out_data <= nibble_to_ascii(shnext[W-1 -: 4], UPPER);
          end
        end
        TERM0: if (adv) begin
          if (NL) begin
            state         <= TERM1;
            byte_out_data <= ASCII_LF;
          end else begin
            state          <= IDLE;
            byte_out_valid <= 1'b0;
          end
        end
        TERM1: if (adv) begin
          state          <= IDLE;
          byte_out_valid <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          byte_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: default instance plus a narrow
// lowercase/space instance, both checked against a byte scoreboard.
module tb_uart_hex_printer;

`ifdef UART_HEX_PRINTER_PREFIX_EN
  localparam int P = 2;
`else
  localparam int P = 0;
`endif
  localparam int N0 = 8 + 2 + P;
  localparam int N1 = 4 + 1 + P;

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] wd0 = '0;
  logic        wv0 = 0, wr0, v0, r0 = 1;
  logic [7:0]  d0;
  logic [15:0] wd1 = '0;
  logic        wv1 = 0, wr1, v1, r1 = 1;
  logic [7:0]  d1;

  always #5 clk = ~clk;

  uart_hex_printer u0 (
    .clk(clk), .rst(rst),
    .word_in_data(wd0), .word_in_valid(wv0), .word_in_ready(wr0),
    .byte_out_data(d0), .byte_out_valid(v0), .byte_out_ready(r0)
  );

  uart_hex_printer #(
    .WORD_BYTES(2), .UPPERCASE(0), .NEWLINE(0)
  ) u1 (
    .clk(clk), .rst(rst),
    .word_in_data(wd1), .word_in_valid(wv1), .word_in_ready(wr1),
    .byte_out_data(d1), .byte_out_valid(v1), .byte_out_ready(r1)
  );

  typedef struct {
    logic [7:0] d;
    bit         last;
  } exp_t;

  typedef struct {
    int          sel;
    logic [31:0] w;
    string       s;
    bit          rnd;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nvec = 0;
  int   nerr = 0;
  int   npop0 = 0;
  bit   rmode0 = 0;
  bit   idle0 = 0, idle1 = 0;
  bit   st0 = 0, st1 = 0;
  logic [7:0] h0, h1;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic void push_exp(input int sel, input string s);
    exp_t e;
    string t;
    t = (P != 0) ? {"0x", s} : s;
    t = (sel == 0) ? {t, "\r\n"} : {t, " "};
    for (int i = 0; i < t.len(); i++) begin
      e.d    = t[i];
      e.last = (i == t.len() - 1);
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    r0 = rmode0 ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v0 && st0) chk("stable0", d0, h0);
      if (v0) chk("busy_ready0", wr0, 0);
      if (idle0) begin
        chk("idle_valid0", v0, 0);
        chk("idle_ready0", wr0, 1);
        idle0 = 0;
      end
      if (v0 && r0) begin
        if (q0.size() == 0) chk("extra0", d0, 0);
        else begin
          e = q0.pop_front();
          chk("char0", d0, e.d);
          if (e.last) idle0 = 1;
          npop0++;
        end
      end
      st0 = v0 && !r0;
      h0  = d0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v1 && st1) chk("stable1", d1, h1);
      if (v1) chk("busy_ready1", wr1, 0);
      if (idle1) begin
        chk("idle_valid1", v1, 0);
        chk("idle_ready1", wr1, 1);
        idle1 = 0;
      end
      if (v1 && r1) begin
        if (q1.size() == 0) chk("extra1", d1, 0);
        else begin
          e = q1.pop_front();
          chk("char1", d1, e.d);
          if (e.last) idle1 = 1;
        end
      end
      st1 = v1 && !r1;
      h1  = d1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake.
  task automatic send(input int sel, input logic [31:0] w,
                      input bit keep, output int waited);
    if (sel == 0) begin wd0 = w; wv0 = 1; end
    else begin wd1 = w[15:0]; wv1 = 1; end
    waited = 0;
    forever begin
      @(negedge clk);
      if ((sel == 0) ? wr0 : wr1) break;
      waited++;
      if (waited > 500) begin
        chk("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin wv0 = 0; wv1 = 0; end
  endtask

  task automatic wait_idle(input int sel, output int k);
    k = 0;
    forever begin
      @(negedge clk);
      if ((sel == 0) ? wr0 : wr1) break;
      k++;
      if (k > 500) begin
        chk("idle_timeout", k, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[10];

  initial begin
    int wt, k, base;
    vt[0] = '{0, 32'hDEADBEEF, "DEADBEEF", 0};
    vt[1] = '{0, 32'h0000A5F0, "0000A5F0", 0};
    vt[2] = '{0, 32'hFFFFFFFF, "FFFFFFFF", 0};
    vt[3] = '{0, 32'h00000000, "00000000", 0};
    vt[4] = '{0, 32'h9ABCDEF0, "9ABCDEF0", 0};
    vt[5] = '{0, 32'h12345678, "12345678", 1};
    vt[6] = '{1, 32'h0000A5F0, "a5f0", 0};
    vt[7] = '{1, 32'h0000007C, "007c", 0};
    vt[8] = '{1, 32'h0000BEEF, "beef", 0};
    vt[9] = '{1, 32'h00000000, "0000", 0};

    #3;
    chk("rst_valid0", v0, 0);
    chk("rst_data0", d0, 0);
    chk("rst_ready0", wr0, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_ready1", wr1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    foreach (vt[i]) begin
      push_exp(vt[i].sel, vt[i].s);
      rmode0 = vt[i].rnd;
      send(vt[i].sel, vt[i].w, 0, wt);
      wait_idle(vt[i].sel, k);
      rmode0 = 0;
      if (!vt[i].rnd)
        chk("cost", k + 1, (vt[i].sel == 0) ? N0 + 1 : N1 + 1);
      chk("drain", (vt[i].sel == 0) ? q0.size() : q1.size(), 0);
    end

    push_exp(0, "CAFEBABE");
    base = npop0;
    send(0, 32'hCAFEBABE, 0, wt);
    k = 0;
    while (npop0 < base + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach", npop0 - base, 3);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_valid", v0, 0);
    chk("mid_data", d0, 0);
    chk("mid_ready", wr0, 0);
    q0.delete();
    idle0 = 0;
    st0 = 0;
    @(posedge clk);
    #1 rst = 0;
    push_exp(0, "00000001");
    send(0, 32'h00000001, 0, wt);
    chk("post_rst_wait", wt, 0);
    wait_idle(0, k);
    chk("post_rst_cost", k, N0);
    chk("post_rst_drain", q0.size(), 0);

    push_exp(0, "00000001");
    push_exp(0, "00000002");
    send(0, 32'h00000001, 1, wt);
    send(0, 32'h00000002, 0, wt);
    chk("b2b_wait", wt, N0);
    wait_idle(0, k);
    chk("b2b_drain", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
